// File: rtl/vip_sobel_edge_detect_8bit.sv
// Three-stage Sobel edge detector on a 3x3 luminance window with realigned sync
// signals, per-pixel edge flag and a saturating per-frame edge-pixel counter.
module vip_sobel_edge_detect_8bit #(
  parameter logic [7:0] THRESH_DEFAULT = 8'd80,
  parameter int         CNT_W          = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             matrix_frame_vsync,
  input  logic             matrix_frame_href,
  input  logic             matrix_frame_clken,
  input  logic [7:0]       matrix_p11,
  input  logic [7:0]       matrix_p12,
  input  logic [7:0]       matrix_p13,
  input  logic [7:0]       matrix_p21,
  input  logic [7:0]       matrix_p22,
  input  logic [7:0]       matrix_p23,
  input  logic [7:0]       matrix_p31,
  input  logic [7:0]       matrix_p32,
  input  logic [7:0]       matrix_p33,
  input  logic [7:0]       threshold,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [7:0]       post_img_y,
  output logic             post_img_bit,
  output logic [CNT_W-1:0] edge_count,
  output logic             edge_count_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Weighted 1-2-1 column/row sum, 10 bits wide (max 1020).
  function automatic logic [9:0] tap3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // Sync bits are carried as {vsync, href, clken}.
  logic [2:0] sync_in;
  logic [2:0] sync_s1_reg;
  logic [2:0] sync_s2_reg;

  assign sync_in = {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken};

  // Index 0 is the horizontal gradient (gx), index 1 the vertical one (gy).
  logic [1:0][9:0] pos_reg;
  logic [1:0][9:0] neg_reg;

  logic       vsync_d_reg;
  logic [7:0] thr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d_reg <= 1'b0;
      thr_reg     <= THRESH_DEFAULT;
    end else begin
      vsync_d_reg <= matrix_frame_vsync;
      if (matrix_frame_vsync && !vsync_d_reg)
        thr_reg <= threshold;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg     <= '0;
      neg_reg     <= '0;
      sync_s1_reg <= '0;
    end else begin
      pos_reg[0]  <= tap3(matrix_p13, matrix_p23, matrix_p33);
      neg_reg[0]  <= tap3(matrix_p11, matrix_p21, matrix_p31);
      pos_reg[1]  <= tap3(matrix_p31, matrix_p32, matrix_p33);
      neg_reg[1]  <= tap3(matrix_p11, matrix_p12, matrix_p13);
      sync_s1_reg <= sync_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_abs
      logic [9:0] abs_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          abs_reg <= '0;
        else if (pos_reg[gi] >= neg_reg[gi])
          abs_reg <= pos_reg[gi] - neg_reg[gi];
        else
          abs_reg <= neg_reg[gi] - pos_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sync_s2_reg <= '0;
    else
      sync_s2_reg <= sync_s1_reg;
  end

  logic [10:0] mag;
  assign mag = {1'b0, g_abs[0].abs_reg} + {1'b0, g_abs[1].abs_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_y       <= '0;
      post_img_bit     <= 1'b0;
    end else begin
      {post_frame_vsync, post_frame_href, post_frame_clken} <= sync_s2_reg;
      if (!sync_s2_reg[1]) begin
        post_img_y   <= '0;
        post_img_bit <= 1'b0;
      end else begin
        post_img_y   <= (mag > 11'd255) ? 8'hFF : mag[7:0];
        post_img_bit <= mag > {3'b000, thr_reg};
      end
    end
  end

  // Frame statistics run off the realigned outputs so the count matches what
  // downstream consumers actually see.
  logic             post_vsync_d_reg;
  logic [CNT_W-1:0] acc_reg;
  logic [CNT_W-1:0] acc_next;
  logic             cnt_inc;
  logic             vsync_fall;

  assign cnt_inc    = post_frame_clken & post_frame_href & post_img_bit;
  assign vsync_fall = post_vsync_d_reg & ~post_frame_vsync;
  assign acc_next   = (cnt_inc && (acc_reg != CNT_MAX)) ? acc_reg + CNT_ONE : acc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_vsync_d_reg <= 1'b0;
      acc_reg          <= '0;
      edge_count       <= '0;
      edge_count_valid <= 1'b0;
    end else begin
      post_vsync_d_reg <= post_frame_vsync;
      edge_count_valid <= vsync_fall;
      if (vsync_fall) begin
        edge_count <= acc_next;
        acc_reg    <= '0;
      end else begin
        acc_reg    <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_vip_sobel_edge_detect_8bit.sv
// Directed bench: stimulus pushes hand-computed pixel and frame-count
// expectations; a negedge monitor pops and compares them.
module tb_vip_sobel_edge_detect_8bit;

  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             matrix_frame_vsync = 1'b0;
  logic             matrix_frame_href = 1'b0;
  logic             matrix_frame_clken = 1'b0;
  logic [7:0]       matrix_p11 = '0, matrix_p12 = '0, matrix_p13 = '0;
  logic [7:0]       matrix_p21 = '0, matrix_p22 = '0, matrix_p23 = '0;
  logic [7:0]       matrix_p31 = '0, matrix_p32 = '0, matrix_p33 = '0;
  logic [7:0]       threshold = 8'd80;
  logic             post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0]       post_img_y;
  logic             post_img_bit;
  logic [CNT_W-1:0] edge_count;
  logic             edge_count_valid;

  vip_sobel_edge_detect_8bit #(.THRESH_DEFAULT(8'd80), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .matrix_frame_vsync(matrix_frame_vsync), .matrix_frame_href(matrix_frame_href),
    .matrix_frame_clken(matrix_frame_clken),
    .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
    .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
    .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
    .threshold(threshold),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_y(post_img_y),
    .post_img_bit(post_img_bit), .edge_count(edge_count),
    .edge_count_valid(edge_count_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic       b;
  } exp_t;

  exp_t pix_q[$];
  int   cnt_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [2:0] hist [0:2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Windows packed as {p11,p12,p13,p21,p22,p23,p31,p32,p33}.
  function automatic logic [71:0] pat_win(input int idx);
    case (idx)
      0: return {9{8'd128}};
      1: return {8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255};
      2: return {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10};
      3: return {8'd0, 8'd0, 8'd0, {6{8'd200}}};
      4: return {8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd20};
      5: return {8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd21};
      default: return {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50};
    endcase
  endfunction

  // Hand-computed magnitudes: 0, 1020, 40, 800, 80, 82, 100 (saturated to 255).
  function automatic logic [7:0] pat_y(input int idx);
    case (idx)
      0: return 8'd0;
      1: return 8'd255;
      2: return 8'd40;
      3: return 8'd255;
      4: return 8'd80;
      5: return 8'd82;
      default: return 8'd100;
    endcase
  endfunction

  task automatic pix(input logic v, input logic h, input logic c, input int pi,
                     input logic eb);
    logic [71:0] w;
    exp_t e;
    w = pat_win(pi);
    matrix_frame_vsync = v;
    matrix_frame_href  = h;
    matrix_frame_clken = c;
    {matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
     matrix_p31, matrix_p32, matrix_p33} = w;
    if (c) begin
      e.y = h ? pat_y(pi) : 8'd0;
      e.b = h ? eb : 1'b0;
      pix_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) pix(v, 1'b0, 1'b0, 6, 1'b0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
    end else begin
      hist[0] <= {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken};
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("sync_delay3", int'({post_frame_vsync, post_frame_href, post_frame_clken}),
        int'(hist[2]));
    if (post_frame_clken) begin
      if (pix_q.size() == 0) begin
        chk("unexpected_pixel", 1, 0);
      end else begin
        e = pix_q.pop_front();
        chk("post_img_y", int'(post_img_y), int'(e.y));
        chk("post_img_bit", int'(post_img_bit), int'(e.b));
      end
    end
    if (edge_count_valid) begin
      if (cnt_q.size() == 0) chk("unexpected_count_pulse", 1, 0);
      else chk("edge_count", int'(edge_count), cnt_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", int'(post_img_y), 0);
    chk("rst_bit", int'(post_img_bit), 0);
    chk("rst_count", int'(edge_count), 0);
    chk("rst_valid", int'(edge_count_valid), 0);
    rst = 1'b0;

    // Default threshold 80 is in force: no vsync rise yet, runtime input ignored.
    threshold = 8'd0;
    pix(1'b0, 1'b1, 1'b1, 4, 1'b0);
    pix(1'b0, 1'b1, 1'b1, 5, 1'b1);
    pix(1'b0, 1'b1, 1'b1, 1, 1'b1);
    pix(1'b0, 1'b1, 1'b1, 0, 1'b0);
    pix(1'b0, 1'b1, 1'b1, 6, 1'b1);
    idle(5, 1'b0);

    // Reset mid-frame: outputs clear at once, interrupted frame never reports.
    threshold = 8'd80;
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b1, 1'b1, 1, 1'b1);
    #2;
    rst = 1'b1;
    pix_q.delete();
    #1;
    chk("async_rst_y", int'(post_img_y), 0);
    chk("async_rst_bit", int'(post_img_bit), 0);
    chk("async_rst_sync", int'({post_frame_vsync, post_frame_href, post_frame_clken}), 0);
    chk("async_rst_valid", int'(edge_count_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    matrix_frame_vsync = 1'b0;
    matrix_frame_href  = 1'b0;
    matrix_frame_clken = 1'b0;
    rst = 1'b0;
    idle(3, 1'b0);

    // 8x4 frame, 5 edges; the last one is driven as vsync drops.
    cnt_q.push_back(5);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        int idx;
        logic e;
        idx = r * 8 + c;
        e = idx inside {3, 10, 17, 24, 31};
        pix(idx != 31, 1'b1, 1'b1, e ? ((idx == 17) ? 3 : 1) : 0, e);
      end
      if (r < 3) idle(2, 1'b1);
    end
    idle(6, 1'b0);

    // Empty frame still pulses with zero.
    cnt_q.push_back(0);
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 1'b1, 0, 1'b0);
    idle(6, 1'b0);

    // Threshold 40 with magnitude 40 gives no edge, mid-frame drop to 0 ignored,
    // href low suppresses output and count.
    cnt_q.push_back(0);
    threshold = 8'd40;
    pix(1'b1, 1'b1, 1'b1, 2, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 2, 1'b0);
    threshold = 8'd0;
    pix(1'b1, 1'b1, 1'b1, 2, 1'b0);
    pix(1'b1, 1'b0, 1'b1, 1, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 2, 1'b0);
    idle(6, 1'b0);

    // Threshold 39 applies from the pixel coinciding with the vsync rise.
    cnt_q.push_back(5);
    threshold = 8'd39;
    pix(1'b1, 1'b1, 1'b1, 2, 1'b1);
    pix(1'b1, 1'b1, 1'b1, 2, 1'b1);
    pix(1'b1, 1'b1, 1'b1, 6, 1'b1);
    pix(1'b1, 1'b1, 1'b1, 3, 1'b1);
    pix(1'b1, 1'b1, 1'b1, 0, 1'b0);
    threshold = 8'd255;
    pix(1'b1, 1'b1, 1'b1, 2, 1'b1);
    idle(8, 1'b0);

    chk("pixels_left", pix_q.size(), 0);
    chk("counts_left", cnt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vip_sobel_edge_detect_8bit.md
# vip_sobel_edge_detect_8bit

Pipelined Sobel edge detector that consumes the 3x3 luminance window and its delayed sync signals produced by the 3x3 matrix generator. Computes gradient magnitude and a binary edge decision per pixel, and outputs both with matching realigned sync signals. Also reports a per-frame edge-pixel count to software/control logic. Sits between the matrix generator and the binarised-image consumers (morphology, display overlay).

## Interface
- `THRESH_DEFAULT`, 8'd80, threshold loaded at reset; edge asserted when magnitude > threshold
- `CNT_W`, 20, width of edge-pixel counter, saturating
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous reset, active-high
- `matrix_frame_vsync`  in  1  frame sync from matrix generator, high during active frame
- `matrix_frame_href`  in  1  line valid
- `matrix_frame_clken`  in  1  pixel valid
- `matrix_p11..matrix_p33`  in  8 each  window; p1x top row, px1 left column
- `threshold`  in  8  runtime threshold, sampled only at frame start
- `post_frame_vsync`  out  1  vsync delayed 3 cycles
- `post_frame_href`  out  1  href delayed 3 cycles
- `post_frame_clken`  out  1  clken delayed 3 cycles
- `post_img_y`  out  8  magnitude saturated to 255
- `post_img_bit`  out  1  edge flag
- `edge_count`  out  CNT_W  edge pixels in last completed frame
- `edge_count_valid`  out  1  one-cycle pulse when `edge_count` updates

## Operation
- Datapath is free-running (advances every clk); validity carried by delayed sync signals only.
- Stage 1: gx_pos = p13+2·p23+p33, gx_neg = p11+2·p21+p31, gy_pos = p31+2·p32+p33, gy_neg = p11+2·p12+p13; each 10 bit unsigned (max 1020).
- Stage 2: gx_abs = |gx_pos−gx_neg|, gy_abs = |gy_pos−gy_neg|; 10 bit, no overflow.
- Stage 3: mag = gx_abs+gy_abs, 11 bit (max 2040); post_img_y = (mag>255) ? 255 : mag[7:0]; post_img_bit = mag > {3'b0, thr_r}.
- When delayed href is 0 at stage 3, post_img_y and post_img_bit forced to 0.
- thr_r: loaded from `threshold` on rising edge of `matrix_frame_vsync` (detected with one register); held otherwise. Mid-frame changes have no effect until next frame.
- Edge counter: acc increments when post_frame_clken & post_frame_href & post_img_bit; saturates at 2^CNT_W−1.
- On falling edge of post_frame_vsync: edge_count <= acc plus any increment qualifying that same cycle (saturated); acc <= 0; edge_count_valid = 1 for that cycle only.
- Counter never updates edge_count without a vsync falling edge; frame with zero edges still produces a pulse with edge_count = 0.

## Timing
- Latency: window sampled at cycle N appears on post_img_y/post_img_bit at cycle N+3; post sync signals equal input sync delayed exactly 3 cycles.
- Reset values: all pipeline registers, post_* outputs, acc, edge_count, edge_count_valid = 0; thr_r = THRESH_DEFAULT; vsync edge-detect registers = 0.
- Reset asserted mid-frame: everything returns to reset values asynchronously; no edge_count_valid pulse for the interrupted frame; after release, first vsync falling edge reports only pixels counted since release.
- Vsync rising at cycle N: thr_r valid from N+1; applies to first pixel of that frame since that pixel reaches stage 3 no earlier than N+3.
- Back-to-back pixels (clken every cycle) fully supported; no stall or backpressure.

## Test plan
- Flat window (all 128), threshold 80 -> after 3 cycles post_img_y=0, post_img_bit=0; post sync = input sync delayed 3.
- Vertical edge p11=p21=p31=0, others 255 -> gx=1020, gy=0, mag=1020; post_img_y=255, post_img_bit=1.
- p13=p23=p33=10, others 0 -> mag=40; threshold 40 gives bit 0, threshold 39 (next frame) gives bit 1; threshold changed mid-frame to 0 leaves bit 0 until next vsync rise.
- 8x4 frame with exactly 5 edge windows, one at last pixel coincident-adjacent to vsync fall -> single edge_count_valid pulse, edge_count=5; next empty frame -> pulse with 0.
- href low with nonzero window -> post_img_y=0, post_img_bit=0, no count increment.
- rst pulsed mid-frame -> all outputs 0 immediately, thr_r=80, no count pulse; following full frame counts correctly.
